regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised successor to the team's 32x64 LEGv8 register file.
- Configurable data width, depth and read-port count; two write ports with a fixed priority; a parametrisable hard-wired zero register.
- Adds a sequential clear engine that zeroes the array one entry per cycle on request.
- Sits in the decode stage of the pipelined datapath. Reads are combinational; all state changes on the falling edge of Clk.

Parameters:
- WIDTH, 64, data width in bits.
- DEPTH, 32, number of registers; must be a power of two, >=2.
- NUM_RD, 2, number of read ports, 1..4.
- ZERO_EN, 1, 1 = register ZERO_IDX reads as 0 and ignores writes.
- ZERO_IDX, 31, index of the hard-wired zero register (XZR).

Ports:
- Clk  in  1  clock; all state updates on falling edge.
- ResetL  in  1  asynchronous, active-low reset.
- RA  in  NUM_RD*AW  read addresses, port i at [i*AW +: AW]; AW = clog2(DEPTH).
- BusR  out  NUM_RD*WIDTH  read data, port i at [i*WIDTH +: WIDTH].
- RW0  in  AW  write address, port 0.
- BusW0  in  WIDTH  write data, port 0.
- RegWr0  in  1  write enable, port 0.
- RW1  in  AW  write address, port 1.
- BusW1  in  WIDTH  write data, port 1.
- RegWr1  in  1  write enable, port 1.
- ClrReq  in  1  request array clear; sampled on the falling edge.
- ClrBusy  out  1  high while the clear sweep runs.
- ClrDone  out  1  one-cycle pulse when the sweep completes.
- WrRej  out  1  combinational; high when RegWr0 or RegWr1 is asserted while ClrBusy is high.

Behaviour:
- Interface: one clock, Clk; reset ResetL is asynchronous, active-low.
- Reset: while ResetL=0, all registers = 0, FSM = IDLE, sweep pointer = 0, ClrBusy = 0, ClrDone = 0. Reset is effective immediately and asynchronously, including mid-sweep (sweep is abandoned).
- Read: BusR[i] = reg[RA[i]], combinational, zero latency.
  - If ZERO_EN=1 and RA[i]==ZERO_IDX, BusR[i] = 0.
  - Reads are not gated by ClrBusy; during a sweep, already-cleared entries return 0.
- Write: on a falling edge with the FSM in IDLE:
  - RegWr0 -> reg[RW0] <= BusW0; RegWr1 -> reg[RW1] <= BusW1.
  - Both enabled with RW0==RW1: port 1 wins.
  - Writes to ZERO_IDX are discarded when ZERO_EN=1.
  - A new value is visible on BusR after the writing edge (no bypass unless the optional feature is enabled).
- FSM, states IDLE, SWEEP, DONE:
  - IDLE: ClrReq=1 at an edge -> SWEEP with ptr=0. Writes presented at that same edge are still performed.
  - SWEEP: each edge, reg[ptr] <= 0 and ptr++. At the edge where ptr==DEPTH-1 -> DONE. The sweep therefore takes exactly DEPTH edges. ClrBusy=1 throughout; writes are ignored and WrRej mirrors the enables; ClrReq is ignored.
  - DONE: ClrDone=1, ClrBusy=0, writes accepted normally. Next edge -> IDLE. A ClrReq seen in DONE is ignored.
- Pointer width is AW; wrap-around is impossible because the FSM exits SWEEP at DEPTH-1.
- ClrBusy and ClrDone are registered outputs.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when RegWrN=1, FSM≠SWEEP, RWN==RA[i], and RWN is not the zero register, BusR[i] returns BusWN combinationally. If both write ports match, port 1 wins. This supports same-cycle write/read forwarding.
- Undefined: BusR always reflects stored contents only.

Decomposition:
- Shared package regfile_pkg: the AW function (clog2), the FSM state typedef (IDLE/SWEEP/DONE), and the default constants WIDTH=64, DEPTH=32, ZERO_IDX=31.
- Sub-module regfile_clr_fsm: state, pointer, ClrBusy/ClrDone, plus per-entry clear strobe and write-gate outputs.
- Top module: array storage, write-priority logic, read muxes and bypass.

Test Plan:
- Reset then read all 32 entries on both ports -> all 0. Write 64'h12345678 to reg 31 -> BusR still 0 (ZERO_EN=1).
- Write reg n = n for n=0..30 via port 0, then read pairs (1,2)..(29,30) -> exact values. RegWr0=0 with BusW0=64'h12345678 -> values unchanged.
- RegWr0=RegWr1=1, RW0=RW1=5, BusW0=64'hAAAA, BusW1=64'hBBBB -> reg5=64'hBBBB. Distinct addresses 6 and 7 -> both written.
- Fill regs with non-zero values, pulse ClrReq -> ClrBusy high for 32 edges, then ClrDone high for exactly 1 cycle. Write during the sweep -> WrRej=1 and the write is dropped. All regs read 0 afterwards.
- Assert ResetL=0 mid-sweep (ptr=10) -> ClrBusy=0 immediately and all regs 0. Normal writes work after release.
- With REGFILE_BYPASS_EN: RA[0]=RW0=3, RegWr0=1, BusW0=64'hDEAD -> BusR[0]=64'hDEAD before the edge. Without the macro -> old value until the falling edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the multi-port register file slice.
// Contents:
//   DEF_WIDTH / DEF_DEPTH / DEF_ZERO_IDX : default geometry (64-bit x 32, XZR at 31)
//   clr_state_t                          : clear-engine states IDLE / SWEEP / DONE
//   addr_width()                         : ceil(log2(depth)), never less than 1

package regfile_pkg;

    localparam int DEF_WIDTH    = 64;
    localparam int DEF_DEPTH    = 32;
    localparam int DEF_ZERO_IDX = 31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_t;

    // Constant function so it can size ports in parameter lists.
    function automatic int addr_width(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm
// Sequential clear engine: on ClrReq it walks a pointer over every entry,
// zeroing one entry per falling edge, then pulses ClrDone for one cycle.
// Ports:
//   Clk        in  clock, state updates on the falling edge
//   ResetL     in  asynchronous active-low reset (abandons any sweep)
//   ClrReq     in  clear request, honoured only in IDLE
//   ClrBusy    out registered, high while the sweep runs
//   ClrDone    out registered, one-cycle completion pulse
//   wr_gate    out high when normal writes may update the array
//   clr_strobe out one-hot per-entry clear for the entry under the pointer

module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = addr_width(DEPTH)
) (
    input  logic             Clk,
    input  logic             ResetL,
    input  logic             ClrReq,
    output logic             ClrBusy,
    output logic             ClrDone,
    output logic             wr_gate,
    output logic [DEPTH-1:0] clr_strobe
);

    clr_state_t      state;
    clr_state_t      state_next;
    logic [AW-1:0]   ptr;
    logic [AW-1:0]   ptr_next;

    // Status flags are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(negedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            ClrBusy <= 1'b0;
            ClrDone <= 1'b0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            ClrBusy <= (state_next == ST_SWEEP);
            ClrDone <= (state_next == ST_DONE);
        end
    end

    // The sweep exits at the last entry, so the pointer never wraps.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            ST_IDLE: begin
                if (ClrReq) begin
                    state_next = ST_SWEEP;
                    ptr_next   = '0;
                end
            end
            ST_SWEEP: begin
                if (ptr == AW'(DEPTH - 1)) begin
                    state_next = ST_DONE;
                end else begin
                    ptr_next = ptr + 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign wr_gate = (state != ST_SWEEP);

    always_comb begin
        clr_strobe = '0;
        if (state == ST_SWEEP) begin
            clr_strobe[ptr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Parametrised multi-read, dual-write register file for the decode stage.
// Reads are combinational; all state changes on the falling edge of Clk.
// Write port 1 has priority over port 0 on an address collision. When
// ZERO_EN is set, entry ZERO_IDX reads as zero and discards writes.
// Optional build macro: REGFILE_BYPASS_EN forwards write data to matching
// read ports in the same cycle (port 1 wins), except during a clear sweep.
// Ports:
//   Clk, ResetL          clock (falling edge), async active-low reset
//   RA    [NUM_RD*AW]    read addresses, port i at [i*AW +: AW]
//   BusR  [NUM_RD*WIDTH] read data, port i at [i*WIDTH +: WIDTH]
//   RW0/BusW0/RegWr0     write port 0
//   RW1/BusW1/RegWr1     write port 1
//   ClrReq               request a full-array clear
//   ClrBusy / ClrDone    clear engine status (registered)
//   WrRej                a write was presented while the sweep is running

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_EN  = 1'b1,
    parameter int ZERO_IDX = DEF_ZERO_IDX,
    localparam int AW      = addr_width(DEPTH)
) (
    input  logic                    Clk,
    input  logic                    ResetL,
    input  logic [NUM_RD*AW-1:0]    RA,
    output logic [NUM_RD*WIDTH-1:0] BusR,
    input  logic [AW-1:0]           RW0,
    input  logic [WIDTH-1:0]        BusW0,
    input  logic                    RegWr0,
    input  logic [AW-1:0]           RW1,
    input  logic [WIDTH-1:0]        BusW1,
    input  logic                    RegWr1,
    input  logic                    ClrReq,
    output logic                    ClrBusy,
    output logic                    ClrDone,
    output logic                    WrRej
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_gate;
    logic [DEPTH-1:0] clr_strobe;
    logic [DEPTH-1:0] we0;
    logic [DEPTH-1:0] we1;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    regfile_clr_fsm #(
        .DEPTH (DEPTH)
    ) u_clr_fsm (
        .Clk        (Clk),
        .ResetL     (ResetL),
        .ClrReq     (ClrReq),
        .ClrBusy    (ClrBusy),
        .ClrDone    (ClrDone),
        .wr_gate    (wr_gate),
        .clr_strobe (clr_strobe)
    );

    assign WrRej = ClrBusy && (RegWr0 || RegWr1);

    // Per-entry write enables; the zero register never gets one.
    always_comb begin
        we0 = '0;
        we1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_gate && !(ZERO_EN && (i == ZERO_IDX))) begin
                we0[i] = RegWr0 && (RW0 == AW'(i));
                we1[i] = RegWr1 && (RW1 == AW'(i));
            end
        end
    end

    // Port 1 is checked first so it wins an address collision.
    always_ff @(negedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clr_strobe[i]) begin
                    regs[i] <= '0;
                end else if (we1[i]) begin
                    regs[i] <= BusW1;
                end else if (we0[i]) begin
                    regs[i] <= BusW0;
                end
            end
        end
    end

    // Zero-register masking comes last so forwarding can never expose
    // data on the hard-wired zero entry.
    always_comb begin
        BusR    = '0;
        rd_addr = '0;
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr = RA[i*AW +: AW];
            rd_data = regs[rd_addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_gate && RegWr0 && (RW0 == rd_addr)) begin
                rd_data = BusW0;
            end
            if (wr_gate && RegWr1 && (RW1 == rd_addr)) begin
                rd_data = BusW1;
            end
`endif
            if (ZERO_EN && (rd_addr == AW'(ZERO_IDX))) begin
                rd_data = '0;
            end
            BusR[i*WIDTH +: WIDTH] = rd_data;
        end
    end

endmodule
